div_unit: RTL

Multi-cycle signed 32-bit divider implementing the MIPS `div` operation, one quotient bit per clock (restoring algorithm on magnitudes, sign fix at end). Sits directly upstream of the HI/LO path. The remainder (`hi_out`) and quotient (`lo_out`) feed the DivCtrl mux, which drives the HI and LO registers. The control unit starts an operation with a one-cycle pulse and waits for `done` before writing HI/LO.

---
 rtl/div_if.sv | 23 ++
 rtl/div_unit.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/div_if.sv
// Handshake and result bundle between the control unit and the multi-cycle divider.
interface div_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, dividend, divisor,
    input  busy, done, div_zero, hi_out, lo_out
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, div_zero, hi_out, lo_out
  );
endinterface

// File: rtl/div_unit.sv
// Signed restoring divider (MIPS div): one quotient bit per clock, sign fix in a final cycle.
// Optional DIV_ZERO_TRAP_EN: a zero divisor skips the iterations and leaves hi/lo untouched.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic  clk,
  input  logic  reset,
  div_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic             dvs_zero;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;

  // Operand magnitudes and one restoring step; trial MSB set means "does not fit".
  always_comb begin
    dvd_mag  = bus.dividend[WIDTH-1] ? WIDTH'(-bus.dividend) : bus.dividend;
    dvs_mag  = bus.divisor[WIDTH-1]  ? WIDTH'(-bus.divisor)  : bus.divisor;
    dvs_zero = (bus.divisor == '0);
    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    trial    = rem_sh - {1'b0, dvsr_q};
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          dvsr_d     = dvs_mag;
          quo_d      = dvd_mag;
          rem_d      = '0;
          count_d    = '0;
          neg_quo_d  = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
          neg_rem_d  = bus.dividend[WIDTH-1];
          div_zero_d = dvs_zero;
`ifdef DIV_ZERO_TRAP_EN
          state_d    = dvs_zero ? FIX : RUN;
`else
          state_d    = RUN;
`endif
        end
      end

      RUN: begin
        rem_d   = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
`ifdef DIV_ZERO_TRAP_EN
        if (!div_zero_q) begin
          lo_d = neg_quo_q ? WIDTH'(-quo_q) : quo_q;
          hi_d = neg_rem_q ? WIDTH'(-rem_q) : rem_q;
        end
`else
        lo_d = neg_quo_q ? WIDTH'(-quo_q) : quo_q;
        hi_d = neg_rem_q ? WIDTH'(-rem_q) : rem_q;
`endif
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvsr_q     <= dvsr_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi_out   = hi_q;
  assign bus.lo_out   = lo_q;

endmodule
